// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit: serial MAC neuron, y = sat((sum x*w + bias<<FRAC) >>> FRAC); define RELU_EN to clamp negatives to 0
module neuron_mac_unit #(
    parameter int N_IN = 3,
    parameter int DW   = 8,
    parameter int FRAC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_IN*DW-1:0]   x_flat,
    input  logic [N_IN*DW-1:0]   w_flat,
    input  logic [DW-1:0]        bias,
    output logic [DW-1:0]        y,
    output logic                 rdy,
    output logic                 valid,
    output logic                 sat
);
    localparam int AW = 2*DW + $clog2(N_IN+1) + 1;
    localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam logic signed [AW-1:0] Y_MAX = AW'(2**(DW-1)-1);
    localparam logic signed [AW-1:0] Y_MIN = -Y_MAX - 1;
    typedef enum logic [2:0] {IDLE, MAC, BIAS, SAT, DONE} state_t;
    state_t state, state_nx;
    logic [N_IN*DW-1:0] x_r, w_r;
    logic signed [DW-1:0] bias_r, xi, wi, y_nx;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0] acc, prod_ext, bias_ext, t;
    logic [IW-1:0] idx;
    logic start, hi, lo, sat_nx;
    assign rdy      = state == IDLE || state == DONE;
    assign valid    = state == DONE;
    assign start    = rdy && en;
    assign xi       = x_r[idx*DW +: DW];
    assign wi       = w_r[idx*DW +: DW];
    assign prod     = xi * wi;
    assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(AW-DW){bias_r[DW-1]}}, bias_r};
    assign t        = acc >>> FRAC;
    assign hi       = t > Y_MAX;
    assign lo       = t < Y_MIN;
`ifdef RELU_EN
    assign y_nx   = hi ? Y_MAX[DW-1:0] : t[AW-1] ? '0 : t[DW-1:0];
    assign sat_nx = hi;
`else
    assign y_nx   = hi ? Y_MAX[DW-1:0] : lo ? Y_MIN[DW-1:0] : t[DW-1:0];
    assign sat_nx = hi || lo;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (en) state_nx = MAC;
            MAC:        if (idx == IW'(N_IN-1)) state_nx = BIAS;
            BIAS:       state_nx = SAT;
            SAT:        state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end
    // operands are captured at the start edge so callers may change them mid-operation
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            y      <= '0;
            sat    <= 1'b0;
            acc    <= '0;
            idx    <= '0;
            x_r    <= '0;
            w_r    <= '0;
            bias_r <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                x_r    <= x_flat;
                w_r    <= w_flat;
                bias_r <= bias;
                acc    <= '0;
                idx    <= '0;
                sat    <= 1'b0;
            end else if (state == MAC) begin
                acc <= acc + prod_ext;
                idx <= idx + 1'b1;
            end else if (state == BIAS) begin
                acc <= acc + (bias_ext <<< FRAC);
            end else if (state == SAT) begin
                y   <= y_nx;
                sat <= sat_nx;
            end
        end
    end
endmodule
